traffic_phase_arbiter: RTL and testbench
========================================

Name: traffic_phase_arbiter

Overview:
Demand-driven phase scheduler for the 4-way intersection. It replaces fixed-time rotation: vehicle sensors and an emergency preempt decide which approach gets green. Approaches are served round-robin, with min/max green, gap-out, yellow and all-red clearance. Outputs drive the same 3-bit light buses as the fixed-time controller, so it is a drop-in for the intersection top level.

Parameters:
MIN_GREEN, 20, minimum green duration in clk cycles (>=1)
MAX_GREEN, 70, maximum green duration while another approach is waiting (>=MIN_GREEN)
YELLOW, 20, yellow duration in cycles (>=1)
ALL_RED, 5, all-red clearance duration in cycles (>=1)
CW, $clog2(MAX_GREEN+1), timer width (derived; also covers YELLOW and ALL_RED, both asserted <=MAX_GREEN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  4  vehicle presence per approach, level, bit0=N bit1=E bit2=S bit3=W
preempt_valid  in  1  emergency preempt request, level
preempt_dir  in  2  preempt approach, 0=N 1=E 2=S 3=W; sampled only while preempt_valid=1
light_N  out  3  north light: 100 red, 010 yellow, 001 green
light_E  out  3  east light, same encoding
light_S  out  3  south light, same encoding
light_W  out  3  west light, same encoding
phase_dir  out  2  approach currently owning the phase
phase_state  out  2  0=ALL_RED 1=GREEN 2=YELLOW
pending  out  4  latched unserved requests

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed): state=ALL_RED, timer=0, phase_dir=0 (N), pending=0000, all lights 100.
- Lights decode combinationally from the registered state and phase_dir. The approach in phase_dir shows 001 in GREEN and 010 in YELLOW. Every other approach shows 100. In ALL_RED all four show 100.
- Timer: cleared on every state entry, increments each cycle in state, saturates at MAX_GREEN.
- Pending: pending[i] is set on any cycle with req[i]=1, except for i==phase_dir while state==GREEN, where presence is being served. Clear happens on the cycle of entry into GREEN for i; clear wins over a simultaneous set.
- ALL_RED: lasts exactly ALL_RED cycles (exit when timer==ALL_RED-1). Next direction is chosen as follows:
  - preempt_valid=1: next = preempt_dir.
  - Otherwise: the first set pending bit searching from phase_dir+1 upward mod 4, with phase_dir itself checked last.
  - Otherwise (no pending): next = phase_dir.
  Then go to GREEN with phase_dir=next.
- GREEN, checked in priority order each cycle:
  - (a) preempt_valid=1 and preempt_dir != phase_dir: go to YELLOW next cycle, ignoring MIN_GREEN.
  - (b) preempt_valid=1 and preempt_dir == phase_dir: hold GREEN.
  - (c) timer < MIN_GREEN-1: hold.
  - (d) no other approach pending: hold indefinitely (rest in green).
  - (e) req[phase_dir]=1 and timer < MAX_GREEN-1: hold (extension).
  - (f) otherwise: go to YELLOW.
  - Net effect: green lasts >= MIN_GREEN cycles, and at most MAX_GREEN cycles once another approach is pending and no preempt holds it.
- YELLOW: lasts exactly YELLOW cycles, then ALL_RED. Preempt does not shorten yellow or all-red.
- Mid-operation reset: lights go to all-red immediately. Pending requests are lost. On release, the full sequence restarts with ALL_RED.
- Simultaneous requests: resolved only by round-robin order at ALL_RED exit. Starvation is impossible without preempt: every pending approach is served within 3 phases.

Decomposition:
- Shared package traffic_pkg holds:
  - light encodings: LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001
  - direction codes: DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3
  - phase state encodings: ALL_RED=0, GREEN=1, YELLOW=2
- One combinational sub-module, tlc_rr_pick4: inputs pending[3:0] and last[1:0]; outputs pick[1:0] and any. Reusable by future pedestrian-phase logic.
- FSM, timer, pending register and light decode stay in traffic_phase_arbiter.

Test Plan:
All scenarios use MIN_GREEN=4, MAX_GREEN=10, YELLOW=2, ALL_RED=1, 10 ns clock.
1. Reset 5 cycles, no req -> 1 cycle all 100, then N=001, E/S/W=100 held for 200 cycles; phase_state=1, phase_dir=0.
2. N green, req=0010 pulsed 1 cycle at timer=0 -> pending=0010; N green 4 cycles total, N=010 for 2 cycles, all 100 for 1 cycle, E=001; pending=0000.
3. req[0] held high, E pending from N green entry -> N green exactly 10 cycles, then yellow; with req[0] low instead -> exactly 4 cycles.
4. From N green, req=1110 pulsed together -> greens served in order E, S, W, each preceded by 2 yellow + 1 all-red cycles.
5. N green at timer=1, preempt_valid=1 with preempt_dir=3 and E pending -> N=010 on next edge; after yellow and all-red, W=001 (not E); W holds while preempt_valid=1; after drop, serves E following MIN_GREEN.
6. Assert rst=0 mid-YELLOW between clock edges -> all lights 100 and pending=0000 before the next edge; after release, scenario 1 sequence repeats.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared encodings for the intersection phase logic: lamp
//                codes, approach direction codes and phase-state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Lamp encodings driven on each 3-bit light bus
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Approach codes
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Phase-state codes (ALL_RED=0, GREEN=1, YELLOW=2). Prefixed with PH_ so
    // they never collide with the ALL_RED/YELLOW timing parameters.
    localparam logic [1:0] PH_ALL_RED = 2'd0;
    localparam logic [1:0] PH_GREEN   = 2'd1;
    localparam logic [1:0] PH_YELLOW  = 2'd2;

    // One-hot mask for an approach code
    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_rr_pick4
//  Description : Combinational round-robin picker over four request bits.
//                Searches last+1, last+2, last+3 (mod 4) and finally last
//                itself. With nothing pending, pick returns last.
//  Ports       : pending[3:0] in  - request bits
//                last[1:0]    in  - most recently served index
//                pick[1:0]    out - selected index
//                any          out - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_rr_pick4
    import traffic_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down to the nearest so the nearest set
    // bit is the final assignment. Offset 0 (last itself) is the default,
    // which also covers the no-request case.
    always_comb begin
        pick  = last;
        w_idx = DIR_N;
        any   = |pending;
        for (int k = 3; k >= 1; k--) begin
            w_idx = last + 2'(k);
            if (pending[w_idx]) begin
                pick = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_arbiter
//  Description : Demand-driven phase scheduler for a 4-way intersection.
//                Round-robin service of latched requests with min/max green,
//                gap-out, yellow and all-red clearance, plus emergency preempt.
//  Ports       : clk            in   system clock (rising edge)
//                rst            in   asynchronous active-low reset
//                req[3:0]       in   presence per approach (N,E,S,W = bit 0..3)
//                preempt_valid  in   emergency preempt request
//                preempt_dir    in   preempt approach
//                light_N/E/S/W  out  lamp buses (100 red, 010 yellow, 001 green)
//                phase_dir      out  approach owning the phase
//                phase_state    out  0 ALL_RED, 1 GREEN, 2 YELLOW
//                pending[3:0]   out  latched unserved requests
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 20,
    parameter int MAX_GREEN = 70,
    parameter int YELLOW    = 20,
    parameter int ALL_RED   = 5,
    // YELLOW and ALL_RED must not exceed MAX_GREEN so this width covers them
    parameter int CW        = $clog2(MAX_GREEN + 1)
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       preempt_valid,
    input  logic [1:0] preempt_dir,
    output logic [2:0] light_N,
    output logic [2:0] light_E,
    output logic [2:0] light_S,
    output logic [2:0] light_W,
    output logic [1:0] phase_dir,
    output logic [1:0] phase_state,
    output logic [3:0] pending
);

    localparam logic [CW-1:0] c_min_last = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] c_max_last = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] c_max      = CW'(MAX_GREEN);
    localparam logic [CW-1:0] c_yel_last = CW'(YELLOW - 1);
    localparam logic [CW-1:0] c_ar_last  = CW'(ALL_RED - 1);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_timer;
    logic [1:0]      r_dir;
    logic [3:0]      r_pending;

    logic [1:0]      w_state_nxt;
    logic [1:0]      w_dir_nxt;
    logic [1:0]      w_pick;
    logic            w_any;
    logic            w_others;
    logic            w_enter_green;
    logic [3:0]      w_set;
    logic [3:0]      w_clr;
    logic [3:0][2:0] w_lamp;

    tlc_rr_pick4 u_pick (
        .pending (r_pending),
        .last    (r_dir),
        .pick    (w_pick),
        .any     (w_any)
    );

    assign w_others = |(r_pending & ~dir_onehot(r_dir));

    // Next-state / next-direction
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        case (r_state)
            PH_ALL_RED: begin
                if (r_timer == c_ar_last) begin
                    w_state_nxt = PH_GREEN;
                    if (preempt_valid) begin
                        w_dir_nxt = preempt_dir;
                    end else if (w_any) begin
                        w_dir_nxt = w_pick;
                    end
                end
            end
            PH_GREEN: begin
                if (preempt_valid) begin
                    // Preempt elsewhere cuts green short; preempt here holds it
                    if (preempt_dir != r_dir) begin
                        w_state_nxt = PH_YELLOW;
                    end
                end else if (r_timer < c_min_last) begin
                    w_state_nxt = PH_GREEN;
                end else if (!w_others) begin
                    w_state_nxt = PH_GREEN;     // rest in green
                end else if (req[r_dir] && (r_timer < c_max_last)) begin
                    w_state_nxt = PH_GREEN;     // extension while occupied
                end else begin
                    w_state_nxt = PH_YELLOW;
                end
            end
            PH_YELLOW: begin
                if (r_timer == c_yel_last) begin
                    w_state_nxt = PH_ALL_RED;
                end
            end
            default: w_state_nxt = PH_ALL_RED;
        endcase
    end

    assign w_enter_green = (r_state != PH_GREEN) && (w_state_nxt == PH_GREEN);

    // The approach being served in green does not latch its own presence;
    // clearing on green entry takes precedence over a same-cycle set.
    assign w_set = req & ~((r_state == PH_GREEN) ? dir_onehot(r_dir) : 4'b0000);
    assign w_clr = w_enter_green ? dir_onehot(w_dir_nxt) : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= PH_ALL_RED;
            r_timer   <= '0;
            r_dir     <= DIR_N;
            r_pending <= 4'b0000;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_pending <= (r_pending | w_set) & ~w_clr;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_timer != c_max) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Lamp decode from registered state only
    always_comb begin
        w_lamp = {4{LIGHT_RED}};
        if (r_state == PH_GREEN) begin
            w_lamp[r_dir] = LIGHT_GREEN;
        end else if (r_state == PH_YELLOW) begin
            w_lamp[r_dir] = LIGHT_YELLOW;
        end
    end

    assign light_N     = w_lamp[0];
    assign light_E     = w_lamp[1];
    assign light_S     = w_lamp[2];
    assign light_W     = w_lamp[3];
    assign phase_dir   = r_dir;
    assign phase_state = r_state;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_arbiter
//  Description : Directed self-checking bench for traffic_phase_arbiter with
//                MIN_GREEN=4, MAX_GREEN=10, YELLOW=2, ALL_RED=1, 10 ns clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_arbiter;

    // Packed {W,S,E,N} lamp patterns
    localparam logic [11:0] c_ar = 12'h924;  // all red
    localparam logic [11:0] c_ng = 12'h921;
    localparam logic [11:0] c_ny = 12'h922;
    localparam logic [11:0] c_eg = 12'h90C;
    localparam logic [11:0] c_ey = 12'h914;
    localparam logic [11:0] c_sg = 12'h864;
    localparam logic [11:0] c_sy = 12'h8A4;
    localparam logic [11:0] c_wg = 12'h324;
    localparam logic [11:0] c_wy = 12'h524;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       preempt_valid = 1'b0;
    logic [1:0] preempt_dir = 2'd0;
    logic [2:0] light_N, light_E, light_S, light_W;
    logic [1:0] phase_dir, phase_state;
    logic [3:0] pending;
    logic [11:0] w_lights;

    int n_tests = 0;
    int n_fail  = 0;

    assign w_lights = {light_W, light_S, light_E, light_N};

    always #5 clk = ~clk;

    traffic_phase_arbiter #(
        .MIN_GREEN (4),
        .MAX_GREEN (10),
        .YELLOW    (2),
        .ALL_RED   (1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .preempt_valid (preempt_valid),
        .preempt_dir   (preempt_dir),
        .light_N       (light_N),
        .light_E       (light_E),
        .light_S       (light_S),
        .light_W       (light_W),
        .phase_dir     (phase_dir),
        .phase_state   (phase_state),
        .pending       (pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // n cycles, each checked for lamp pattern and phase state
    task automatic run(input string tag, input logic [11:0] lt, input logic [1:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 32'(w_lights), 32'(lt));
            chk({tag, "_st"}, 32'(phase_state), 32'(st));
        end
    endtask

    // Leaves rst released at a falling edge, i.e. inside the first ALL_RED cycle
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        preempt_valid = 1'b0;
        preempt_dir = 2'd0;
        repeat (5) @(negedge clk);
        chk("rst_lights", 32'(w_lights), 32'(c_ar));
        chk("rst_state", 32'(phase_state), 32'd0);
        chk("rst_dir", 32'(phase_dir), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_lights", 32'(w_lights), 32'(c_ar));
    endtask

    initial begin
        // 1: rest in N green after reset
        do_reset();
        run("s1_ng", c_ng, 2'd1, 200);
        chk("s1_dir", 32'(phase_dir), 32'd0);

        // 2: E pulse at timer 0 -> 4-cycle N green, 2 yellow, 1 all-red, E green
        do_reset();
        run("s2_ng", c_ng, 2'd1, 1);
        req = 4'b0010;
        run("s2_ng", c_ng, 2'd1, 1);
        req = 4'b0000;
        chk("s2_pend", 32'(pending), 32'h2);
        run("s2_ng", c_ng, 2'd1, 2);
        run("s2_ny", c_ny, 2'd2, 2);
        run("s2_ar", c_ar, 2'd0, 1);
        run("s2_eg", c_eg, 2'd1, 1);
        chk("s2_pend_clr", 32'(pending), 32'h0);
        chk("s2_dir", 32'(phase_dir), 32'd1);

        // 3: N occupied while E waits -> green extends to MAX_GREEN = 10
        do_reset();
        run("s3_ng", c_ng, 2'd1, 1);
        req = 4'b0011;
        run("s3_ng", c_ng, 2'd1, 9);
        run("s3_ny", c_ny, 2'd2, 1);
        req = 4'b0000;
        run("s3_ny", c_ny, 2'd2, 1);
        run("s3_ar", c_ar, 2'd0, 1);
        run("s3_eg", c_eg, 2'd1, 1);

        // 4: E,S,W requested together -> served in round-robin order
        do_reset();
        run("s4_ng", c_ng, 2'd1, 1);
        req = 4'b1110;
        run("s4_ng", c_ng, 2'd1, 1);
        req = 4'b0000;
        run("s4_ng", c_ng, 2'd1, 2);
        run("s4_ny", c_ny, 2'd2, 2);
        run("s4_ar", c_ar, 2'd0, 1);
        run("s4_eg", c_eg, 2'd1, 1);
        chk("s4_pend", 32'(pending), 32'hC);
        run("s4_eg", c_eg, 2'd1, 3);
        run("s4_ey", c_ey, 2'd2, 2);
        run("s4_ar", c_ar, 2'd0, 1);
        run("s4_sg", c_sg, 2'd1, 4);
        run("s4_sy", c_sy, 2'd2, 2);
        run("s4_ar", c_ar, 2'd0, 1);
        run("s4_wg", c_wg, 2'd1, 1);
        chk("s4_pend_clr", 32'(pending), 32'h0);
        run("s4_wg_rest", c_wg, 2'd1, 10);

        // 5: preempt to W at N timer=1 with E pending
        do_reset();
        run("s5_ng", c_ng, 2'd1, 1);
        req = 4'b0010;
        run("s5_ng", c_ng, 2'd1, 1);
        req = 4'b0000;
        chk("s5_pend", 32'(pending), 32'h2);
        preempt_valid = 1'b1;
        preempt_dir = 2'd3;
        run("s5_ny", c_ny, 2'd2, 2);
        run("s5_ar", c_ar, 2'd0, 1);
        run("s5_wg", c_wg, 2'd1, 1);
        chk("s5_dir_w", 32'(phase_dir), 32'd3);
        run("s5_wg_hold", c_wg, 2'd1, 20);
        chk("s5_pend_e", 32'(pending), 32'h2);
        preempt_valid = 1'b0;
        run("s5_wy", c_wy, 2'd2, 2);
        run("s5_ar", c_ar, 2'd0, 1);
        run("s5_eg", c_eg, 2'd1, 5);
        chk("s5_dir_e", 32'(phase_dir), 32'd1);

        // 6: asynchronous reset mid-yellow
        do_reset();
        run("s6_ng", c_ng, 2'd1, 1);
        req = 4'b0010;
        run("s6_ng", c_ng, 2'd1, 3);
        req = 4'b0000;
        run("s6_ny", c_ny, 2'd2, 1);
        chk("s6_pend", 32'(pending), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_async_lights", 32'(w_lights), 32'(c_ar));
        chk("s6_async_pend", 32'(pending), 32'h0);
        chk("s6_async_state", 32'(phase_state), 32'd0);
        chk("s6_async_dir", 32'(phase_dir), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_rel_lights", 32'(w_lights), 32'(c_ar));
        run("s6_ng", c_ng, 2'd1, 5);
        chk("s6_dir", 32'(phase_dir), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
